// File: rtl/instr_fetch_pkg.sv
// +--------------------------------------------------------------------------+
// | instr_fetch_pkg : shared types and constants for the instruction fetcher  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package instr_fetch_pkg;

    localparam int          INSTR_BYTES      = 4;
    localparam int          INSTR_WIDTH      = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_if.sv
// +--------------------------------------------------------------------------+
// | instr_fetch_if : imem request/response, decode stream and redirect bus    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface instr_fetch_if
    import instr_fetch_pkg::*;
#(
    parameter int PC_WIDTH = 32
);
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_ready;
    logic                   imem_rvalid;
    logic [INSTR_WIDTH-1:0] imem_rdata;

    logic                   inst_valid;
    logic                   inst_ready;
    logic [INSTR_WIDTH-1:0] inst_data;
    logic [PC_WIDTH-1:0]    inst_pc;

    logic                   redirect_valid;
    logic [PC_WIDTH-1:0]    redirect_pc;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
        input  imem_ready, imem_rvalid, imem_rdata, inst_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
        output imem_ready, imem_rvalid, imem_rdata, inst_ready,
               redirect_valid, redirect_pc
    );

endinterface

`default_nettype wire

// File: rtl/instr_fetch_fifo.sv
// +--------------------------------------------------------------------------+
// | fetch_fifo : synchronous prefetch FIFO with single-cycle flush            |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             flush_i,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] push_data_i,
    input  wire logic             pop_i,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [WIDTH-1:0]      head_o
);

    localparam int                 c_PTR_W    = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_PTR_W:0]   c_CNT_ONE  = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W:0]   c_CNT_FULL = (c_PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q;
    logic [c_PTR_W-1:0] rd_ptr_q;
    logic [c_PTR_W:0]   count_q;
    logic               w_push;
    logic               w_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == c_CNT_FULL);
    assign head_o  = mem_q[rd_ptr_q];
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (!rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + c_CNT_ONE;
                2'b01:   count_q <= count_q - c_CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// +--------------------------------------------------------------------------+
// | instr_fetch : single-outstanding instruction fetcher with prefetch FIFO   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                  PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(DEFAULT_RESET_PC),
    parameter int                  FIFO_DEPTH = 4
) (
    input  wire logic      clk,
    input  wire logic      rst,
    instr_fetch_if.master  bus
);

    localparam logic [PC_WIDTH-1:0] c_STEP       = PC_WIDTH'(INSTR_BYTES);
    localparam logic [PC_WIDTH-1:0] c_ALIGN_MASK = ~PC_WIDTH'(INSTR_BYTES - 1);

    fetch_state_t          state_q;
    fetch_state_t          state_d;
    logic [PC_WIDTH-1:0]   fetch_pc_q;
    logic [PC_WIDTH-1:0]   fetch_pc_d;
    logic [PC_WIDTH-1:0]   req_pc_q;
    logic                  run_q;
    logic                  w_req;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [PC_WIDTH+INSTR_WIDTH-1:0] w_head;

    assign w_accept = w_req && bus.imem_ready;
    assign w_pop    = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        w_req      = 1'b0;
        w_push     = 1'b0;
        case (state_q)
            FETCH: begin
                // run_q keeps the request low for the whole cycle after a reset edge.
                w_req = run_q && !w_fifo_full;
                if (w_req && bus.imem_ready) begin
                    fetch_pc_d = fetch_pc_q + c_STEP;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid) begin
                    w_push  = 1'b1;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (bus.imem_rvalid) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        if (bus.redirect_valid) begin
            w_push     = 1'b0;
            fetch_pc_d = bus.redirect_pc & c_ALIGN_MASK;
            // Go to DRAIN only while a response is still owed by imem.
            case (state_q)
                FETCH:       state_d = (w_req && bus.imem_ready) ? DRAIN : FETCH;
                WAIT, DRAIN: state_d = bus.imem_rvalid ? FETCH : DRAIN;
                default:     state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC & c_ALIGN_MASK;
            req_pc_q   <= RESET_PC & c_ALIGN_MASK;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            run_q      <= 1'b1;
            if (w_accept) begin
                req_pc_q <= fetch_pc_q;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (PC_WIDTH + INSTR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (bus.redirect_valid),
        .push_i      (w_push),
        .push_data_i ({req_pc_q, bus.imem_rdata}),
        .pop_i       (w_pop),
        .empty_o     (w_fifo_empty),
        .full_o      (w_fifo_full),
        .head_o      (w_head)
    );

    assign bus.imem_req   = w_req;
    assign bus.imem_addr  = fetch_pc_q;
    assign bus.inst_valid = !w_fifo_empty;
    assign bus.inst_pc    = w_head[PC_WIDTH+INSTR_WIDTH-1:INSTR_WIDTH];
    assign bus.inst_data  = w_head[INSTR_WIDTH-1:0];

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// +--------------------------------------------------------------------------+
// | tb_instr_fetch : directed bench with imem responder and scoreboard        |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam int          c_PCW    = 32;
    localparam logic [31:0] c_RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_if #(.PC_WIDTH(c_PCW)) bus ();

    instr_fetch #(
        .PC_WIDTH   (c_PCW),
        .RESET_PC   (c_RST_PC),
        .FIFO_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          total   = 0;
    int          bad     = 0;
    int          accepts = 0;
    int          pops    = 0;
    int          lat     = 1;
    int          pops_base;
    int          n;
    logic        mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = '0;
    logic [31:0] model_pc = c_RST_PC;
    logic [63:0] exp_q [$];

    function automatic logic [31:0] dfun(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        step(1);
    endtask

    // imem model: accepts a request, answers after lat cycles, reset by the same rst
    assign bus.imem_rvalid = mem_busy && (mem_cnt == 0);
    assign bus.imem_rdata  = mem_busy ? dfun(mem_addr) : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (!rst) begin
            mem_busy <= 1'b0;
        end else if (bus.imem_req && bus.imem_ready) begin
            mem_busy <= 1'b1;
            mem_cnt  <= lat - 1;
            mem_addr <= bus.imem_addr;
        end else if (mem_busy) begin
            if (mem_cnt == 0) mem_busy <= 1'b0;
            else              mem_cnt  <= mem_cnt - 1;
        end
    end

    // scoreboard: expectation pushed on request accept, popped on decode handshake
    always @(negedge clk) begin
        logic [63:0] e;
        #4;
        if (!rst) begin
            exp_q.delete();
            model_pc = c_RST_PC;
        end else begin
            if (bus.imem_req && bus.imem_ready) begin
                accepts++;
                check("one_outstanding", 64'(mem_busy), 64'd0);
                check("fetch_addr", 64'(bus.imem_addr), 64'(model_pc));
                if (!bus.redirect_valid) exp_q.push_back({model_pc, dfun(model_pc)});
                model_pc = model_pc + 32'd4;
            end
            if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
                pops++;
                check("pop_has_expect", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("inst_pc", 64'(bus.inst_pc), 64'(e[63:32]));
                    check("inst_data", 64'(bus.inst_data), 64'(e[31:0]));
                end
            end
            if (bus.redirect_valid) begin
                exp_q.delete();
                model_pc = {bus.redirect_pc[31:2], 2'b00};
            end
        end
    end

    initial begin
        rst                = 1'b0;
        bus.imem_ready     = 1'b1;
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        // reset state and first fetches
        step(2);
        check("rst_imem_req", 64'(bus.imem_req), 64'd0);
        check("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
        rst = 1'b1;
        step(1);
        check("first_req", 64'(bus.imem_req), 64'd1);
        check("first_addr", 64'(bus.imem_addr), 64'(c_RST_PC));
        step(10);
        check("stream_pops", 64'(pops >= 3), 64'd1);

        // back-pressure fills the FIFO, then drains in order
        bus.inst_ready = 1'b0;
        do_reset();
        accepts = 0;
        step(20);
        check("full_accepts", 64'(accepts), 64'd4);
        check("full_no_req", 64'(bus.imem_req), 64'd0);
        check("full_valid", 64'(bus.inst_valid), 64'd1);
        check("stall_head_pc", 64'(bus.inst_pc), 64'h0);
        check("stall_head_data", 64'(bus.inst_data), 64'(dfun(32'h0)));
        pops_base = pops;
        bus.inst_ready = 1'b1;
        step(12);
        check("drain_pops", 64'(pops - pops_base >= 4), 64'd1);
        check("resume_fetch", 64'(accepts >= 5), 64'd1);

        // redirect while waiting on 0x8
        lat = 3;
        do_reset();
        n = 0;
        while (!(bus.imem_req && bus.imem_addr == 32'h8) && n < 40) begin step(1); n++; end
        check("wait_addr8_timeout", 64'(n < 40), 64'd1);
        step(1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0103;
        step(1);
        bus.redirect_valid = 1'b0;
        check("redir_flush_empty", 64'(bus.inst_valid), 64'd0);
        check("redir_drain_no_req", 64'(bus.imem_req), 64'd0);
        n = 0;
        while (!bus.imem_req && n < 20) begin step(1); n++; end
        check("redir_req_timeout", 64'(n < 20), 64'd1);
        check("redir_addr", 64'(bus.imem_addr), 64'h100);
        step(15);

        // redirect coinciding with a response and a decode pop
        lat = 1;
        bus.inst_ready = 1'b0;
        do_reset();
        n = 0;
        while (!(bus.imem_rvalid && bus.inst_valid) && n < 30) begin step(1); n++; end
        check("coincide_timeout", 64'(n < 30), 64'd1);
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
        step(1);
        bus.redirect_valid = 1'b0;
        check("coincide_empty", 64'(bus.inst_valid), 64'd0);
        check("coincide_req", 64'(bus.imem_req), 64'd1);
        check("coincide_addr", 64'(bus.imem_addr), 64'h200);
        step(10);

        // reset while waiting with three queued entries
        lat = 3;
        bus.inst_ready = 1'b0;
        do_reset();
        accepts = 0;
        n = 0;
        while (accepts < 4 && n < 60) begin step(1); n++; end
        check("fill3_timeout", 64'(n < 60), 64'd1);
        check("fill3_valid", 64'(bus.inst_valid), 64'd1);
        rst = 1'b0;
        step(1);
        check("midrst_inst_valid", 64'(bus.inst_valid), 64'd0);
        check("midrst_imem_req", 64'(bus.imem_req), 64'd0);
        rst = 1'b1;
        lat = 1;
        bus.inst_ready = 1'b1;
        step(1);
        check("midrst_first_req", 64'(bus.imem_req), 64'd1);
        check("midrst_first_addr", 64'(bus.imem_addr), 64'(c_RST_PC));
        step(12);

        // fetch address wraps past the top of the address space
        do_reset();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFE;
        step(1);
        bus.redirect_valid = 1'b0;
        n = 0;
        while (!bus.imem_req && n < 20) begin step(1); n++; end
        check("top_req_timeout", 64'(n < 20), 64'd1);
        check("top_addr", 64'(bus.imem_addr), 64'hFFFF_FFFC);
        step(1);
        n = 0;
        while (!bus.imem_req && n < 20) begin step(1); n++; end
        check("wrap_req_timeout", 64'(n < 20), 64'd1);
        check("wrap_addr", 64'(bus.imem_addr), 64'h0);
        step(8);

        // stop fetching and confirm the scoreboard empties
        bus.imem_ready = 1'b0;
        step(8);
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        check("final_empty", 64'(bus.inst_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameters: PC_WIDTH, 32, PC width in bits; RESET_PC, 32'h0000_0000, first fetch address; FIFO_DEPTH, 4, prefetch entries (power of 2, >=2).
REQ-002 SHALL have ports: clk  input  1  clock, all state on rising edge.
REQ-003 SHALL have: rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have: imem_req  output  1  fetch request valid; imem_addr  output  PC_WIDTH  byte address, bits[1:0]=0; imem_ready  input  1  request accepted when imem_req&&imem_ready.
REQ-005 SHALL have: imem_rvalid  input  1  response valid; imem_rdata  input  32  instruction word.
REQ-006 SHALL have: inst_valid  output  1; inst_ready  input  1; inst_data  output  32; inst_pc  output  PC_WIDTH -- decode-side valid/ready stream to the datapath.
REQ-007 SHALL have: redirect_valid  input  1  branch/jump taken; redirect_pc  input  PC_WIDTH  new fetch address.

Function
REQ-008 SHALL hold fetch_pc; each accepted request SHALL increment it by 4, wrapping modulo 2^PC_WIDTH.
REQ-009 SHALL keep at most one imem request outstanding.
REQ-010 SHALL use FSM states FETCH, WAIT, DRAIN.
REQ-011 In FETCH: imem_req=1 iff fifo_count < FIFO_DEPTH; imem_addr=fetch_pc; on accept -> WAIT.
REQ-012 In WAIT: on imem_rvalid push {fetch-time pc, imem_rdata} into FIFO, -> FETCH; no request issued in WAIT (peak throughput 1 instruction per 2 cycles).
REQ-013 In DRAIN: on imem_rvalid discard response, -> FETCH.
REQ-014 imem_rvalid SHALL be ignored in FETCH.
REQ-015 inst_valid SHALL equal FIFO non-empty; inst_data/inst_pc SHALL be the FIFO head; pop on inst_valid&&inst_ready.
REQ-016 inst_data/inst_pc SHALL stay stable while inst_valid&&!inst_ready.
REQ-017 Simultaneous push and pop SHALL keep fifo_count unchanged; push into full FIFO SHALL not occur (guaranteed by REQ-011).
REQ-018 On redirect_valid: FIFO flushed (inst_valid=0 next cycle), fetch_pc <= {redirect_pc[PC_WIDTH-1:2],2'b00}; redirect overrides same-cycle push, pop and pc increment.
REQ-019 Redirect state rule: request outstanding (WAIT, or FETCH with same-cycle accept) -> DRAIN; WAIT with same-cycle imem_rvalid -> FETCH (response dropped); otherwise -> FETCH.
REQ-020 Redirect in DRAIN SHALL stay in DRAIN and update fetch_pc.
REQ-021 Wrong-path instructions SHALL never appear on inst_valid after a redirect.

Reset
REQ-022 While rst=0 at a clock edge: state=FETCH, fetch_pc=RESET_PC, FIFO empty, imem_req=0 and inst_valid=0 in the following cycle.
REQ-023 Reset mid-operation SHALL abandon any outstanding request; imem is reset by the same rst, so no stale response is expected and REQ-014 drops it if one arrives.
REQ-024 First request SHALL issue the first cycle after rst returns to 1, address RESET_PC.

Structure
REQ-025 Shared package SHALL hold fetch_state_t enum (FETCH, WAIT, DRAIN), INSTR_BYTES=4, default RESET_PC.
REQ-026 Prefetch buffer SHALL be a separate sub-module fetch_fifo (sync FIFO, flush input, width PC_WIDTH+32).
REQ-027 Top SHALL contain FSM, fetch_pc register and imem/decode glue only.

Verification
REQ-028 Reset release, imem_ready=1, 1-cycle latency, inst_ready=1 -> addresses 0x0,0x4,0x8 in order; inst_pc matches each inst_data.
REQ-029 inst_ready=0 for 20 cycles -> exactly 4 requests (0x0..0xC), imem_req=0 afterwards; inst_ready=1 -> 4 pops in order, fetching resumes at 0x10.
REQ-030 Redirect to 0x103 while WAIT for 0x8 -> response for 0x8 discarded, next request address 0x100, FIFO empty one cycle after redirect.
REQ-031 Redirect same cycle as imem_rvalid and inst_valid&&inst_ready -> no push, FIFO empty next cycle, state FETCH, next address redirect_pc.
REQ-032 rst=0 while WAIT with 3 FIFO entries -> next cycle inst_valid=0, imem_req=0; after release first address RESET_PC.
REQ-033 fetch_pc=0xFFFF_FFFC accepted -> next request address 0x0000_0000.
